reg_file_mp: RTL

//  Parametrised multi-port integer register file for the RISC-V core. Has NUM_RD

---
 rtl/reg_file_mp.sv | 96 +++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with registered read ports, optional
// write-to-read bypass and an integrated busy scoreboard.
module reg_file_mp #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_SIZE = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int BYPASS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0]           rd_en,
  input  logic [NUM_RD*ADDR_SIZE-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]      rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*ADDR_SIZE-1:0] wr_addr,
  input  logic [NUM_WR*XLEN-1:0]      wr_data,
  input  logic                        rsv_en,
  input  logic [ADDR_SIZE-1:0]        rsv_addr,
  output logic [NUM_REGS-1:0]         busy_vec
);

  logic [XLEN-1:0]        regs   [NUM_REGS];
  logic [XLEN-1:0]        wr_val [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_hit;
  logic [NUM_REGS-1:0]    rsv_hit;
  logic [NUM_REGS-1:0]    busy_q;
  logic [NUM_REGS-1:0]    busy_next;
  logic [NUM_RD*XLEN-1:0] rd_data_next;
  logic [NUM_RD-1:0]      rd_busy_next;

  // Per-register write resolution. Index 0 and out-of-range addresses never
  // match a loop index, so those writes and reservations fall away here.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first; this lets later ports override earlier ones and avoids latches.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) wr_val[i] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      // Ascending port order: the highest-indexed matching port wins.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(i))) begin
          wr_hit[i] = 1'b1;
          wr_val[i] = wr_data[w*XLEN +: XLEN];
        end
      end
      rsv_hit[i] = rsv_en && (rsv_addr == ADDR_SIZE'(i));
    end
  end

  // A new reservation beats a same-cycle release: the new owner keeps it busy.
  assign busy_next = (busy_q & ~wr_hit) | rsv_hit;

  // Read mux; x0 and out-of-range addresses match nothing and read as 0/not busy.
  always_comb begin
    rd_data_next = '0;
    rd_busy_next = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_addr[p*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(i)) begin
          rd_data_next[p*XLEN +: XLEN] = ((BYPASS != 0) && wr_hit[i]) ? wr_val[i] : regs[i];
          rd_busy_next[p]              = busy_q[i] & ~wr_hit[i];
        end
      end
    end
  end

  // NOTE: state updates use non-blocking '<=' so every register samples
  // pre-edge values. The storage array is reset too, because the architectural
  // state must read as zero immediately after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy_q  <= '0;
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) regs[i] <= wr_val[i];
      end
      busy_q <= busy_next;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p*XLEN +: XLEN] <= rd_data_next[p*XLEN +: XLEN];
          rd_busy[p]              <= rd_busy_next[p];
        end
      end
    end
  end

  assign busy_vec = busy_q;

endmodule
